// File: rtl/reg_vec_pipe.sv
// Multi-channel valid/ready register pipeline with per-channel stage-0 load enables and flush.
// Optional 16-bit output transfer counter (xfer_cnt) is built when REG_VEC_PIPE_CNT_EN is defined.
module reg_vec_pipe #(
  parameter int unsigned      WIDTH   = 3,
  parameter int unsigned      NCH     = 3,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data
`ifdef REG_VEC_PIPE_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  localparam int unsigned DW = NCH * WIDTH;
  localparam int unsigned CW = 16;

  logic [DEPTH-1:0] r_v;
  logic [DW-1:0]    r_d [DEPTH];
  logic [DEPTH-1:0] w_adv;
  logic [DW-1:0]    w_d0_nxt;
  logic             w_in_xfer;

  // A stage advances when the consumer takes the word or any later stage has a bubble.
  always_comb begin : adv_chain
    logic l_acc;
    l_acc = out_ready | ~r_v[DEPTH-1];
    w_adv = '0;
    w_adv[DEPTH-1] = l_acc;
    for (int s = int'(DEPTH) - 2; s >= 0; s--) begin
      l_acc = l_acc | ~r_v[s+1];
      w_adv[s] = l_acc;
    end
  end

  assign in_ready  = w_adv[0] & ~flush;
  assign w_in_xfer = in_valid & in_ready;
  assign out_valid = r_v[DEPTH-1] & ~flush;
  assign out_data  = r_d[DEPTH-1];

  // Disabled channels keep their previous stage-0 contents.
  always_comb begin
    w_d0_nxt = r_d[0];
    for (int k = 0; k < int'(NCH); k++) begin
      if (ch_en[k]) begin
        w_d0_nxt[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int s = 0; s < int'(DEPTH); s++) begin
        r_d[s] <= {NCH{RST_VAL}};
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0] <= w_in_xfer;
        if (w_in_xfer) begin
          r_d[0] <= w_d0_nxt;
        end
      end
      for (int s = 1; s < int'(DEPTH); s++) begin
        if (w_adv[s]) begin
          r_v[s] <= r_v[s-1];
          if (r_v[s-1]) begin
            r_d[s] <= r_d[s-1];
          end
        end
      end
    end
  end

`ifdef REG_VEC_PIPE_CNT_EN
  logic          w_out_xfer;
  logic [CW-1:0] r_xfer_cnt;

  assign w_out_xfer = out_valid & out_ready;

  // Free-running wrap counter of accepted output words; flush has no effect on it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt <= '0;
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + CW'(1);
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_reg_vec_pipe.sv
// Scoreboard bench for reg_vec_pipe: directed scenarios followed by randomized traffic.
// Counter checks are included when REG_VEC_PIPE_CNT_EN is defined.
module tb_reg_vec_pipe;

  localparam int unsigned W  = 3;
  localparam int unsigned N  = 3;
  localparam int unsigned D  = 2;
  localparam int unsigned DW = W * N;
  localparam logic [W-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  ch_en = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef REG_VEC_PIPE_CNT_EN
  logic [15:0]   xfer_cnt;
  logic [15:0]   m_cnt = '0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_d0 = {N{RV}};

  logic          s_in_ready;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;

  reg_vec_pipe #(.WIDTH(W), .NCH(N), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ch_en(ch_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef REG_VEC_PIPE_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [N-1:0] en);
    logic [DW-1:0] m;
    m = old;
    for (int k = 0; k < int'(N); k++) begin
      if (en[k]) m[k*W +: W] = nw[k*W +: W];
    end
    return m;
  endfunction

  // Drive one cycle, sample just before the edge and update the reference model.
  task automatic step(input logic rs, input logic v, input logic [DW-1:0] data,
                      input logic [N-1:0] en, input logic ordy, input logic fl);
    @(negedge clk);
    rst = rs; in_valid = v; in_data = data; ch_en = en; out_ready = ordy; flush = fl;
    #3;
    s_in_ready = in_ready; s_out_valid = out_valid; s_out_data = out_data;
    if (rs) begin
      sb.delete();
      m_d0 = {N{RV}};
    end else if (fl) begin
      chk("in_ready_during_flush", 32'(in_ready), 32'd0);
      sb.delete();
    end else begin
      if (sb.size() == 0) chk("in_ready_when_empty", 32'(in_ready), 32'd1);
      if (!ordy && sb.size() == int'(D)) chk("in_ready_when_full", 32'(in_ready), 32'd0);
      if (v && in_ready) begin
        m_d0 = merge(m_d0, data, en);
        sb.push_back(m_d0);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
`ifdef REG_VEC_PIPE_CNT_EN
      m_cnt = '0;
`endif
    end else begin
`ifdef REG_VEC_PIPE_CNT_EN
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
      if (flush) chk("out_valid_during_flush", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(sb.pop_front()));
        end
`ifdef REG_VEC_PIPE_CNT_EN
        m_cnt = m_cnt + 16'd1;
`endif
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h1FF, 3'b111, 1'b1, 1'b1);

    // Reset then idle
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("rst_out_valid", 32'(s_out_valid), 32'd0);
    chk("rst_in_ready", 32'(s_in_ready), 32'd1);
    chk("rst_out_data", 32'(s_out_data), 32'h000);

    // Streaming latency
    step(1'b0, 1'b1, 9'h1A3, 3'b111, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9'h05C, 3'b111, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("stream_c2_valid", 32'(s_out_valid), 32'd1);
    chk("stream_c2_data", 32'(s_out_data), 32'h1A3);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("stream_c3_valid", 32'(s_out_valid), 32'd1);
    chk("stream_c3_data", 32'(s_out_data), 32'h05C);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("stream_c4_valid", 32'(s_out_valid), 32'd0);

    // Backpressure
    step(1'b0, 1'b1, 9'h0A5, 3'b111, 1'b0, 1'b0);
    chk("bp_accept0", 32'(s_in_ready), 32'd1);
    step(1'b0, 1'b1, 9'h13C, 3'b111, 1'b0, 1'b0);
    chk("bp_accept1", 32'(s_in_ready), 32'd1);
    step(1'b0, 1'b1, 9'h1E1, 3'b111, 1'b0, 1'b0);
    chk("bp_full_ready", 32'(s_in_ready), 32'd0);
    chk("bp_hold_data", 32'(s_out_data), 32'h0A5);
    step(1'b0, 1'b1, 9'h1E1, 3'b111, 1'b0, 1'b0);
    chk("bp_full_ready2", 32'(s_in_ready), 32'd0);
    step(1'b0, 1'b1, 9'h1E1, 3'b111, 1'b1, 1'b0);
    chk("bp_release_ready", 32'(s_in_ready), 32'd1);
    chk("bp_out0", 32'(s_out_data), 32'h0A5);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("bp_out1_valid", 32'(s_out_valid), 32'd1);
    chk("bp_out1", 32'(s_out_data), 32'h13C);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("bp_out2_valid", 32'(s_out_valid), 32'd1);
    chk("bp_out2", 32'(s_out_data), 32'h1E1);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("bp_empty", 32'(s_out_valid), 32'd0);

    // Channel mask
    step(1'b0, 1'b1, 9'h1FF, 3'b111, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9'h000, 3'b010, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 3'b000, 1'b1, 1'b0);
    chk("mask_first", 32'(s_out_data), 32'h1FF);
    step(1'b0, 1'b0, '0, 3'b000, 1'b1, 1'b0);
    chk("mask_second_valid", 32'(s_out_valid), 32'd1);
    chk("mask_second", 32'(s_out_data), 32'h1C7);

    // Flush with a simultaneous input word
    step(1'b0, 1'b1, 9'h0F0, 3'b111, 1'b1, 1'b0);
    step(1'b0, 1'b1, 9'h00F, 3'b111, 1'b1, 1'b1);
    chk("flush_c1_valid", 32'(s_out_valid), 32'd0);
    step(1'b0, 1'b1, 9'h155, 3'b111, 1'b1, 1'b0);
    chk("flush_c2_valid", 32'(s_out_valid), 32'd0);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("flush_c3_valid", 32'(s_out_valid), 32'd0);
    step(1'b0, 1'b0, '0, 3'b111, 1'b1, 1'b0);
    chk("flush_c4_valid", 32'(s_out_valid), 32'd1);
    chk("flush_c4_data", 32'(s_out_data), 32'h155);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           DW'($urandom),
           N'($urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 39) == 0));
    end

    // Drain and confirm nothing was lost
    for (int i = 0; i < int'(D) + 2; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream discards in-flight words
    step(1'b0, 1'b1, 9'h0AA, 3'b111, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h111, 3'b111, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("rst_mid_valid", 32'(s_out_valid), 32'd0);
    chk("rst_mid_data", 32'(s_out_data), 32'h000);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_vec_pipe.md
REG_VEC_PIPE -- requirements
Module: reg_vec_pipe

Interface
REQ-001 Parameter WIDTH, default 3: bit width of each channel.
REQ-002 Parameter NCH, default 3: number of channels; legal range is 1 or more.
REQ-003 Parameter DEPTH, default 2: number of register stages; legal range is 1 or more.
REQ-004 Parameter RST_VAL, default 0: per-channel data reset value, WIDTH bits.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input word offered.
REQ-008 in_ready  output  1  pipeline accepts the input word this cycle.
REQ-009 in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 ch_en  input  NCH  per-channel load enable at stage 0.
REQ-011 flush  input  1  discards all in-flight words.
REQ-012 out_valid  output  1  the last stage holds a word.
REQ-013 out_ready  input  1  the consumer accepts the word.
REQ-014 out_data  output  NCH*WIDTH  data of the last stage, packed the same way as in_data.
REQ-015 xfer_cnt  output  16  count of output transfers; present only when REG_VEC_PIPE_CNT_EN is defined.

Function
REQ-016 Each stage s SHALL hold a valid bit v[s] and an NCH*WIDTH data register d[s].
REQ-017 The last stage SHALL advance when out_ready=1 or v[DEPTH-1]=0.
REQ-018 Stage s below the last SHALL advance when stage s+1 advances or v[s+1]=0.
REQ-019 in_ready SHALL equal the advance condition of stage 0, and SHALL be forced to 0 while flush=1.
REQ-020 An input transfer SHALL occur when in_valid=1 and in_ready=1.
REQ-021 On an input transfer, channels with ch_en[k]=1 SHALL load in_data into d[0]; channels with ch_en[k]=0 SHALL keep their d[0] value.
REQ-022 On advance, stage s+1 SHALL take v[s] and d[s]; d[s+1] SHALL load only when v[s]=1.
REQ-023 When stage 0 advances without an input transfer, v[0] SHALL clear.
REQ-024 Data SHALL never be lost or duplicated; a stage holds its contents whenever it does not advance.
REQ-025 With out_ready held at 1, latency from input transfer to out_valid SHALL be exactly DEPTH cycles.
REQ-026 Sustained throughput SHALL be 1 word/cycle, including while the pipeline is full and out_ready=1.
REQ-027 out_valid SHALL equal v[DEPTH-1] and SHALL be forced to 0 while flush=1; out_data SHALL equal d[DEPTH-1] at all times.
REQ-028 A cycle with flush=1 SHALL clear all v[s] at the next edge, take no input, count no output, and leave data registers unchanged.
REQ-029 If flush and in_valid are both 1 in the same cycle, the input word SHALL be dropped.
REQ-030 When the pipeline is full and out_ready=0, in_ready SHALL be 0 in that same cycle.
REQ-031 Ready paths SHALL be combinational, from out_ready to in_ready; valid and data paths SHALL be fully registered.

Reset
REQ-032 While rst=1, all v[s] SHALL clear and every channel of every d[s] SHALL load RST_VAL at the clock edge.
REQ-033 In the cycle after reset is released, out_valid SHALL be 0, in_ready SHALL be 1 and out_data SHALL be all channels RST_VAL.
REQ-034 Reset asserted mid-stream SHALL discard in-flight words; rst SHALL take priority over flush and over handshakes.

Configuration
REQ-035 Macro REG_VEC_PIPE_CNT_EN SHALL control the transfer counter.
REQ-036 With REG_VEC_PIPE_CNT_EN defined, xfer_cnt SHALL increment on each output transfer (out_valid=1 and out_ready=1).
REQ-037 With REG_VEC_PIPE_CNT_EN defined, xfer_cnt SHALL wrap from 0xFFFF to 0x0000, clear on rst and be unaffected by flush.
REQ-038 With REG_VEC_PIPE_CNT_EN undefined, the xfer_cnt port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification (WIDTH=3, NCH=3, DEPTH=2, RST_VAL=0)
REQ-039 Reset then idle: out_valid=0, in_ready=1, out_data=9'h000.
REQ-040 Streaming: ch_en=3'b111 and out_ready=1, with words 9'h1A3 at cycle 0 and 9'h05C at cycle 1, SHALL give out_valid=1 with 9'h1A3 at cycle 2 and 9'h05C at cycle 3.
REQ-041 Backpressure: out_ready=0 with 3 words offered SHALL accept 2 words, then give in_ready=0; out_data SHALL hold the first word; raising out_ready SHALL deliver all 3 in order with no gaps.
REQ-042 Channel mask: load 9'h1FF with ch_en=3'b111, then load 9'h000 with ch_en=3'b010; the second word SHALL emerge as 9'h1C7.
REQ-043 Flush: flush at cycle 1 while streaming, together with in_valid=1, SHALL give out_valid=0 during cycle 1 and for the following 2 cycles; the dropped word SHALL never appear.
REQ-044 Counter (REG_VEC_PIPE_CNT_EN defined): with xfer_cnt preloaded to 0xFFFE, 3 transfers SHALL read 0xFFFF, 0x0000, 0x0001; asserting rst SHALL return it to 0.
